// File: rtl/ball_pkg.sv
// Shared types and constants for the pong ball motion engine.
// No logic; state encoding and direction polarity only.
package ball_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HELD = 2'd2
   } state_t;

   localparam logic DIR_POS = 1'b1;
   localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/ball_motion_if.sv
// Control/status bundle between frame logic and the ball engine.
// Slave side is the engine; master side is the controller/renderer.
interface ball_motion_if #(
   parameter int W      = 10,
   parameter int STEP_W = 4
);
   logic              tick;
   logic              pause;
   logic              launch;
   logic [W-1:0]      x_init;
   logic [W-1:0]      y_init;
   logic              x_dir_init;
   logic              y_dir_init;
   logic [STEP_W-1:0] x_step;
   logic [STEP_W-1:0] y_step;
   logic              deflect_left;
   logic              deflect_right;
   logic [W-1:0]      x_pos;
   logic [W-1:0]      y_pos;
   logic              x_dir;
   logic              y_dir;
   logic              active;
   logic              bounce_y;
   logic              miss_left;
   logic              miss_right;

   modport master (
      output tick, pause, launch, x_init, y_init, x_dir_init, y_dir_init,
             x_step, y_step, deflect_left, deflect_right,
      input  x_pos, y_pos, x_dir, y_dir, active, bounce_y, miss_left, miss_right
   );

   modport slave (
      input  tick, pause, launch, x_init, y_init, x_dir_init, y_dir_init,
             x_step, y_step, deflect_left, deflect_right,
      output x_pos, y_pos, x_dir, y_dir, active, bounce_y, miss_left, miss_right
   );
endinterface

// File: rtl/ball_motion_axis_stepper.sv
// One-axis step with clamp at 0 and LIMIT; purely combinational.
// hit_* flag a clamp; a zero step never clamps or reverses.
module axis_stepper
   import ball_pkg::*;
#(
   parameter int W      = 10,
   parameter int STEP_W = 4,
   parameter int LIMIT  = 471
) (
   input  logic [W-1:0]      i_pos,
   input  logic              i_dir,
   input  logic [STEP_W-1:0] i_step,
   output logic [W-1:0]      o_pos,
   output logic              o_dir,
   output logic              o_hit_low,
   output logic              o_hit_high
);
   localparam logic [W:0] LIM = (W+1)'(LIMIT);

   logic [W:0] w_pos_ext;
   logic [W:0] w_step_ext;
   logic [W:0] w_sum;
   logic [W:0] w_diff;

   assign w_pos_ext  = {1'b0, i_pos};
   assign w_step_ext = {{(W+1-STEP_W){1'b0}}, i_step};
   assign w_sum      = w_pos_ext + w_step_ext;
   assign w_diff     = w_pos_ext - w_step_ext;

   always_comb begin
      o_pos      = i_pos;
      o_dir      = i_dir;
      o_hit_low  = 1'b0;
      o_hit_high = 1'b0;
      if (i_step != '0) begin
         if (i_dir == DIR_POS) begin
            if (w_sum >= LIM) begin
               o_pos      = LIM[W-1:0];
               o_dir      = DIR_NEG;
               o_hit_high = 1'b1;
            end else begin
               o_pos = w_sum[W-1:0];
            end
         end else begin
            if (w_pos_ext <= w_step_ext) begin
               o_pos     = '0;
               o_dir     = DIR_POS;
               o_hit_low = 1'b1;
            end else begin
               o_pos = w_diff[W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Ball motion engine: FSM + registered position/dir, one update per frame tick.
// Outputs change the cycle after tick/launch; no backpressure.
module ball_motion
   import ball_pkg::*;
#(
   parameter int W         = 10,
   parameter int STEP_W    = 4,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479,
   parameter int BALL_SIZE = 8,
   parameter int X_RESET   = 320,
   parameter int Y_RESET   = 240
) (
   input  logic         clk,
   input  logic         reset_n,
   ball_motion_if.slave bus
);
   localparam int XL = X_MAX - BALL_SIZE;
   localparam int YL = Y_MAX - BALL_SIZE;

   state_t       r_state, w_state_nxt;
   logic [W-1:0] r_x_pos, r_y_pos, w_x_pos_nxt, w_y_pos_nxt;
   logic         r_x_dir, r_y_dir, w_x_dir_nxt, w_y_dir_nxt;
   logic         r_active;
   logic         r_bounce_y, r_miss_left, r_miss_right;
   logic         w_bounce_nxt, w_miss_l_nxt, w_miss_r_nxt;

   logic         w_x_dir_eff;
   logic [W-1:0] w_x_step_pos, w_y_step_pos;
   logic         w_x_step_dir, w_y_step_dir;
   logic         w_x_lo, w_x_hi, w_y_lo, w_y_hi;

   // Deflects resolve before the move; simultaneous left/right cancel out.
   always_comb begin
      w_x_dir_eff = r_x_dir;
      if (bus.deflect_left && !bus.deflect_right)
         w_x_dir_eff = DIR_POS;
      else if (bus.deflect_right && !bus.deflect_left)
         w_x_dir_eff = DIR_NEG;
   end

   axis_stepper #(.W(W), .STEP_W(STEP_W), .LIMIT(XL)) u_x_axis (
      .i_pos      (r_x_pos),
      .i_dir      (w_x_dir_eff),
      .i_step     (bus.x_step),
      .o_pos      (w_x_step_pos),
      .o_dir      (w_x_step_dir),
      .o_hit_low  (w_x_lo),
      .o_hit_high (w_x_hi)
   );

   axis_stepper #(.W(W), .STEP_W(STEP_W), .LIMIT(YL)) u_y_axis (
      .i_pos      (r_y_pos),
      .i_dir      (r_y_dir),
      .i_step     (bus.y_step),
      .o_pos      (w_y_step_pos),
      .o_dir      (w_y_step_dir),
      .o_hit_low  (w_y_lo),
      .o_hit_high (w_y_hi)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_x_pos_nxt  = r_x_pos;
      w_y_pos_nxt  = r_y_pos;
      w_x_dir_nxt  = r_x_dir;
      w_y_dir_nxt  = r_y_dir;
      w_bounce_nxt = 1'b0;
      w_miss_l_nxt = 1'b0;
      w_miss_r_nxt = 1'b0;
      if (bus.launch) begin
         w_x_pos_nxt = bus.x_init;
         w_y_pos_nxt = bus.y_init;
         w_x_dir_nxt = bus.x_dir_init;
         w_y_dir_nxt = bus.y_dir_init;
         w_state_nxt = bus.pause ? HELD : RUN;
      end else begin
         unique case (r_state)
            RUN: begin
               if (bus.pause) begin
                  w_state_nxt = HELD;
               end else if (bus.tick) begin
                  w_y_pos_nxt  = w_y_step_pos;
                  w_y_dir_nxt  = w_y_step_dir;
                  w_bounce_nxt = w_y_lo | w_y_hi;
                  w_x_pos_nxt  = w_x_step_pos;
                  // A miss ends the rally but leaves x_dir as it was.
                  w_x_dir_nxt  = (w_x_lo | w_x_hi) ? w_x_dir_eff : w_x_step_dir;
                  w_miss_l_nxt = w_x_lo;
                  w_miss_r_nxt = w_x_hi;
                  if (w_x_lo || w_x_hi)
                     w_state_nxt = IDLE;
               end
            end
            HELD: begin
               if (!bus.pause)
                  w_state_nxt = RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_x_pos      <= W'(X_RESET);
         r_y_pos      <= W'(Y_RESET);
         r_x_dir      <= DIR_POS;
         r_y_dir      <= DIR_NEG;
         r_active     <= 1'b0;
         r_bounce_y   <= 1'b0;
         r_miss_left  <= 1'b0;
         r_miss_right <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_x_pos      <= w_x_pos_nxt;
         r_y_pos      <= w_y_pos_nxt;
         r_x_dir      <= w_x_dir_nxt;
         r_y_dir      <= w_y_dir_nxt;
         r_active     <= (w_state_nxt != IDLE);
         r_bounce_y   <= w_bounce_nxt;
         r_miss_left  <= w_miss_l_nxt;
         r_miss_right <= w_miss_r_nxt;
      end
   end

   assign bus.x_pos      = r_x_pos;
   assign bus.y_pos      = r_y_pos;
   assign bus.x_dir      = r_x_dir;
   assign bus.y_dir      = r_y_dir;
   assign bus.active     = r_active;
   assign bus.bounce_y   = r_bounce_y;
   assign bus.miss_left  = r_miss_left;
   assign bus.miss_right = r_miss_right;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion; expected values are hand-computed (XL=631, YL=471).
module tb_ball_motion;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   ball_motion_if #(.W(10), .STEP_W(4)) bus ();

   ball_motion dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // {x_pos, y_pos, x_dir, y_dir, active}
   function automatic logic [22:0] st();
      return {bus.x_pos, bus.y_pos, bus.x_dir, bus.y_dir, bus.active};
   endfunction

   // {bounce_y, miss_left, miss_right}
   function automatic logic [2:0] pl();
      return {bus.bounce_y, bus.miss_left, bus.miss_right};
   endfunction

   function automatic logic [22:0] mk(input int x, input int y, input logic xd,
                                       input logic yd, input logic act);
      return {10'(x), 10'(y), xd, yd, act};
   endfunction

   task automatic idle_inputs();
      bus.tick = 0; bus.pause = 0; bus.launch = 0;
      bus.x_init = '0; bus.y_init = '0; bus.x_dir_init = 0; bus.y_dir_init = 0;
      bus.x_step = '0; bus.y_step = '0;
      bus.deflect_left = 0; bus.deflect_right = 0;
   endtask

   task automatic do_launch(input int x, input int y, input logic xd, input logic yd);
      @(negedge clk);
      bus.launch = 1; bus.x_init = 10'(x); bus.y_init = 10'(y);
      bus.x_dir_init = xd; bus.y_dir_init = yd;
      @(negedge clk);
      bus.launch = 0;
   endtask

   task automatic do_tick(input logic dl, input logic dr);
      @(negedge clk);
      bus.tick = 1; bus.deflect_left = dl; bus.deflect_right = dr;
      @(negedge clk);
      bus.tick = 0; bus.deflect_left = 0; bus.deflect_right = 0;
   endtask

   task automatic chk_st(input string name, input logic [22:0] exp);
      logic [22:0] got;
      got = st();
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got x=%0d y=%0d xd=%b yd=%b act=%b, want x=%0d y=%0d xd=%b yd=%b act=%b",
                  name, got[22:13], got[12:3], got[2], got[1], got[0],
                  exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
      else n_pass++;
   endtask

   task automatic chk_pl(input string name, input logic [2:0] exp);
      logic [2:0] got;
      got = pl();
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got {bounce,missL,missR}=%b want %b", name, got, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      repeat (2) @(negedge clk);
      chk_st("reset_state", mk(320, 240, 1, 0, 0));
      chk_pl("reset_pulses", 3'b000);
      reset_n = 1;
      bus.x_step = 4'd3; bus.y_step = 4'd3;
      repeat (3) do_tick(1'b0, 1'b0);
      chk_st("idle_ticks_no_motion", mk(320, 240, 1, 0, 0));
   endtask

   task automatic test_launch_run();
      bus.x_step = 4'd3; bus.y_step = 4'd2;
      do_launch(100, 100, 1, 1);
      chk_st("launch_load", mk(100, 100, 1, 1, 1));
      for (int i = 0; i < 5; i++) begin
         do_tick(1'b0, 1'b0);
         chk_pl("run_no_pulse", 3'b000);
      end
      chk_st("run_5_ticks", mk(115, 110, 1, 1, 1));
   endtask

   task automatic test_bottom_bounce();
      bus.x_step = 4'd0; bus.y_step = 4'd4;
      do_launch(100, 470, 1, 1);
      do_tick(1'b0, 1'b0);
      chk_st("bottom_clamp", mk(100, 471, 1, 0, 1));
      chk_pl("bottom_bounce_pulse", 3'b100);
      @(negedge clk);
      chk_pl("bottom_bounce_one_cycle", 3'b000);
      do_tick(1'b0, 1'b0);
      chk_st("after_bounce", mk(100, 467, 1, 0, 1));
   endtask

   task automatic test_top_bounce_step0();
      bus.x_step = 4'd0; bus.y_step = 4'd2;
      do_launch(100, 1, 1, 0);
      do_tick(1'b0, 1'b0);
      chk_st("top_clamp", mk(100, 0, 1, 1, 1));
      chk_pl("top_bounce_pulse", 3'b100);
      bus.y_step = 4'd0;
      do_launch(100, 0, 1, 0);
      do_tick(1'b0, 1'b0);
      chk_st("step0_no_move", mk(100, 0, 1, 0, 1));
      chk_pl("step0_no_event", 3'b000);
   endtask

   task automatic test_left_miss();
      bus.x_step = 4'd3; bus.y_step = 4'd0;
      do_launch(2, 100, 0, 1);
      do_tick(1'b0, 1'b0);
      chk_st("left_miss_state", mk(0, 100, 0, 1, 0));
      chk_pl("left_miss_pulse", 3'b010);
      @(negedge clk);
      chk_pl("left_miss_one_cycle", 3'b000);
      bus.x_step = 4'd5; bus.y_step = 4'd5;
      do_tick(1'b0, 1'b0);
      chk_st("after_miss_frozen", mk(0, 100, 0, 1, 0));
   endtask

   task automatic test_right_miss_bounce();
      bus.x_step = 4'd1; bus.y_step = 4'd4;
      do_launch(630, 470, 1, 1);
      do_tick(1'b0, 1'b0);
      chk_st("right_miss_state", mk(631, 471, 1, 0, 0));
      chk_pl("right_miss_and_bounce", 3'b101);
   endtask

   task automatic test_deflect();
      bus.x_step = 4'd2; bus.y_step = 4'd0;
      do_launch(10, 100, 0, 1);
      do_tick(1'b1, 1'b0);
      chk_st("deflect_left", mk(12, 100, 1, 1, 1));
      chk_pl("deflect_left_no_miss", 3'b000);
      do_tick(1'b1, 1'b1);
      chk_st("deflect_both", mk(14, 100, 1, 1, 1));
      do_tick(1'b0, 1'b1);
      chk_st("deflect_right", mk(12, 100, 0, 1, 1));
   endtask

   task automatic test_pause_launch();
      bus.x_step = 4'd1; bus.y_step = 4'd1;
      do_launch(50, 50, 1, 1);
      @(negedge clk);
      bus.pause = 1;
      @(negedge clk);
      repeat (3) do_tick(1'b0, 1'b0);
      chk_st("paused_frozen", mk(50, 50, 1, 1, 1));
      // Launch with tick and pause in the same cycle: load only, land in HELD.
      @(negedge clk);
      bus.launch = 1; bus.tick = 1; bus.x_init = 10'd200; bus.y_init = 10'd200;
      bus.x_dir_init = 1; bus.y_dir_init = 1;
      @(negedge clk);
      bus.launch = 0; bus.tick = 0;
      chk_st("launch_overrides_tick", mk(200, 200, 1, 1, 1));
      do_tick(1'b0, 1'b0);
      chk_st("held_no_motion", mk(200, 200, 1, 1, 1));
      @(negedge clk);
      bus.pause = 0; bus.tick = 1;
      @(negedge clk);
      bus.tick = 0;
      chk_st("unpause_cycle_no_motion", mk(200, 200, 1, 1, 1));
      do_tick(1'b0, 1'b0);
      chk_st("resumed_motion", mk(201, 201, 1, 1, 1));
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.tick = 1;
      repeat (2) @(negedge clk);
      bus.tick = 0;
      chk_st("back_to_back_ticks", mk(203, 203, 1, 1, 1));
      // Async reset mid-run must clear without waiting for an edge.
      #2 reset_n = 0;
      #1;
      chk_st("async_reset_mid_run", mk(320, 240, 1, 0, 0));
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      test_reset();
      test_launch_run();
      test_bottom_bounce();
      test_top_bounce_step0();
      test_left_miss();
      test_right_miss_bounce();
      test_deflect();
      test_pause_launch();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
# ball_motion

Parametrised ball motion engine for the pong playfield, successor to the single-step ball block. Advances a ball position by programmable per-axis step sizes on each frame tick, reflects off top/bottom walls, accepts paddle deflections, and reports left/right misses to the scoring logic. Sits between the frame-tick generator and the renderer/collision logic; all outputs are registered.

## Interface
- W, 10, coordinate width in bits
- STEP_W, 4, step-size input width
- X_MAX, 639, rightmost playfield pixel
- Y_MAX, 479, bottom playfield pixel
- BALL_SIZE, 8, ball edge length in pixels; limits are XL = X_MAX-BALL_SIZE, YL = Y_MAX-BALL_SIZE
- X_RESET, 320 / Y_RESET, 240, position loaded by reset

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame strobe; motion happens only on tick
- pause  in  1  level; freezes motion while high
- launch  in  1  one-cycle; loads init values and starts motion
- x_init, y_init  in  W  position loaded on launch
- x_dir_init, y_dir_init  in  1  direction loaded on launch (1 = increasing coordinate)
- x_step, y_step  in  STEP_W  pixels moved per tick, sampled on each tick
- deflect_left  in  1  left paddle hit; forces x_dir = 1
- deflect_right  in  1  right paddle hit; forces x_dir = 0
- x_pos, y_pos  out  W  ball top-left position
- x_dir, y_dir  out  1  current direction
- active  out  1  high in RUN or HELD
- bounce_y  out  1  one-cycle pulse on top/bottom reflection
- miss_left, miss_right  out  1  one-cycle pulse when ball reaches x=0 / x=XL

## Operation
- States: IDLE (no motion), RUN (moving), HELD (paused).
- Reset: state IDLE, x_pos=X_RESET, y_pos=Y_RESET, x_dir=1, y_dir=0, active=0, all pulses 0.
- launch (any state): load x_init, y_init, x_dir_init, y_dir_init; next state RUN if pause=0 else HELD. Launch overrides tick, deflect and pause-transition in the same cycle; no motion that cycle.
- RUN & pause=1 → HELD; HELD & pause=0 → RUN. Pause transition cycle has no motion even if tick=1.
- RUN & tick & pause=0: one motion update:
  - Deflects applied first: deflect_left sets x_dir=1, deflect_right sets x_dir=0; both high → x_dir unchanged. Updated dir is used for this tick's move.
  - Arithmetic in W+1 bits, step zero-extended. Step 0 on an axis: no movement, no events on that axis.
  - Y: dir=1 and y_pos+y_step >= YL → y_pos=YL, y_dir=0, bounce_y. dir=0 and y_pos <= y_step → y_pos=0, y_dir=1, bounce_y. Else y_pos ± y_step.
  - X: dir=1 and x_pos+x_step >= XL → x_pos=XL, miss_right, state IDLE. dir=0 and x_pos <= x_step → x_pos=0, miss_left, state IDLE. Else x_pos ± x_step. x_dir not changed on miss.
  - Miss and bounce_y in the same tick: both pulse; Y update still applied.
- IDLE/HELD: tick and deflects ignored, position/dir hold.

## Timing
- Registered outputs; motion visible the cycle after the tick edge. Pulses high for exactly the one cycle following the causing tick.
- launch → new x_pos/y_pos and active=1 the next cycle.
- reset_n assertion mid-operation clears immediately (async); release synchronised to clk by upstream reset bridge.
- tick spacing ≥ 2 cycles assumed by system; back-to-back ticks still produce one update each.

## Structure
- ball_pkg: state enum (IDLE, RUN, HELD), DIR_POS=1 / DIR_NEG=0 constants.
- Sub-module axis_stepper (parameters W, STEP_W, LIMIT): combinational next pos, next dir, hit_low, hit_high from pos, dir, step; instantiated once per axis. Top holds FSM, registers, deflect and pulse logic.

## Test plan
- Reset: reset_n=0 → x=320, y=240, x_dir=1, y_dir=0, active=0; ticks before launch → no motion.
- Launch (100,100,1,1), steps 3/2, 5 ticks → x=115, y=110, no pulses.
- Bottom bounce: y=470, y_dir=1, y_step=4, tick → y=471, y_dir=0, bounce_y one cycle; next tick y=467.
- Left miss: x=2, x_dir=0, x_step=3, tick → x=0, miss_left one cycle, active stays 1? no → state IDLE, active=0; further ticks no motion.
- Deflect: x=10, x_dir=0, x_step=2, deflect_left with tick → x=12, x_dir=1, no miss; both deflects high → x_dir unchanged.
- Pause/launch precedence: pause high 3 ticks → position frozen, active=1; launch with pause=1 → loads, state HELD; pause low → motion resumes next tick.
